apb_slave_bank: RTL and testbench

Parametrised APB completer that replaces the pass-through/random-read peripheral model with real storage: NUM_SLAVES independently selected register banks, each DEPTH words of DATA_WIDTH bits. It sits on the APB side of the AHB-to-APB bridge, consumes the bridge's pwrite/penable/psel/paddr/pwdata, and returns registered pr_data, pready (with programmable wait states) and pslverr.

---
 rtl/apb_slave_bank.sv | 118 +++++++++++
 tb/tb_apb_slave_bank.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/apb_slave_bank.sv
// APB completer with NUM_SLAVES register banks of DEPTH words and programmable wait states.
// Define APB_SLVERR_EN to report bad select/address as pslverr; otherwise such accesses are aliased.
module apb_slave_bank #(
  parameter int NUM_SLAVES  = 3,
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int DEPTH       = 16,
  parameter int WAIT_STATES = 0
) (
  input  logic                  Hclk,
  input  logic                  Hresetn,
  input  logic                  pwrite,
  input  logic                  penable,
  input  logic [NUM_SLAVES-1:0] psel,
  input  logic [ADDR_WIDTH-1:0] paddr,
  input  logic [DATA_WIDTH-1:0] pw_data,
  output logic [DATA_WIDTH-1:0] pr_data,
  output logic                  pready,
  output logic                  pslverr
);

  localparam int WW = $clog2(DEPTH);
  localparam int BW = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t                state;
  logic [BW-1:0]         bank_q;
  logic [WW-1:0]         word_q;
  logic                  write_q;
  logic                  err_q;
  logic [3:0]            cnt;
  logic [DATA_WIDTH-1:0] mem [NUM_SLAVES][DEPTH];

  logic [BW-1:0]         sel_bank;
  logic [WW-1:0]         sel_word;
  logic                  sel_err;

  // Lowest set psel bit wins; only matters when multi-hot is not flagged as an error.
  always_comb begin
    sel_bank = '0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--)
      if (psel[i]) sel_bank = BW'(i);
    sel_word = paddr[2 +: WW];
  end

`ifdef APB_SLVERR_EN
  assign sel_err = ((psel & (psel - NUM_SLAVES'(1))) != '0) ||
                   (paddr >= ADDR_WIDTH'(DEPTH * 4)) ||
                   (paddr[1:0] != 2'b00);
`else
  logic unused_addr;
  assign unused_addr = ^paddr;
  assign sel_err     = 1'b0;
`endif

  always_ff @(posedge Hclk) begin
    if (Hresetn) begin
      state   <= IDLE;
      bank_q  <= '0;
      word_q  <= '0;
      write_q <= 1'b0;
      err_q   <= 1'b0;
      cnt     <= '0;
      pr_data <= '0;
      pready  <= 1'b0;
      pslverr <= 1'b0;
      for (int b = 0; b < NUM_SLAVES; b++)
        for (int w = 0; w < DEPTH; w++)
          mem[b][w] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (psel != '0 && !penable) begin
            state   <= ACCESS;
            bank_q  <= sel_bank;
            word_q  <= sel_word;
            write_q <= pwrite;
            err_q   <= sel_err;
            cnt     <= 4'(WAIT_STATES);
            // No wait states: response is loaded straight from the setup decode.
            if (WAIT_STATES == 0) begin
              pready  <= 1'b1;
              pslverr <= sel_err;
              pr_data <= (!pwrite && !sel_err) ? mem[sel_bank][sel_word] : '0;
            end
          end
        end
        ACCESS: begin
          if (psel == '0) begin
            state   <= IDLE;
            cnt     <= '0;
            pready  <= 1'b0;
            pslverr <= 1'b0;
            pr_data <= '0;
          end else if (pready) begin
            if (penable) begin
              if (write_q && !err_q) mem[bank_q][word_q] <= pw_data;
              state   <= IDLE;
              pready  <= 1'b0;
              pslverr <= 1'b0;
              pr_data <= '0;
            end
          end else if (cnt != '0) begin
            cnt <= cnt - 4'd1;
            if (cnt == 4'd1) begin
              pready  <= 1'b1;
              pslverr <= err_q;
              pr_data <= (!write_q && !err_q) ? mem[bank_q][word_q] : '0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_slave_bank.sv
// Directed bench: one bank with no wait states, one with three, sharing the APB bus wires.
module tb_apb_slave_bank;

`ifdef APB_SLVERR_EN
  localparam bit SLV = 1'b1;
`else
  localparam bit SLV = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pwrite = 1'b0;
  logic        penable = 1'b0;
  logic [31:0] paddr = '0;
  logic [31:0] pw_data = '0;
  logic [2:0]  psel0 = '0;
  logic [2:0]  psel3 = '0;
  logic [31:0] prd0, prd3;
  logic        pready0, pready3, pslverr0, pslverr3;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  apb_slave_bank #(.NUM_SLAVES(3), .DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH(16), .WAIT_STATES(0)) dut0 (
    .Hclk(clk), .Hresetn(rst), .pwrite(pwrite), .penable(penable), .psel(psel0),
    .paddr(paddr), .pw_data(pw_data), .pr_data(prd0), .pready(pready0), .pslverr(pslverr0));

  apb_slave_bank #(.NUM_SLAVES(3), .DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH(16), .WAIT_STATES(3)) dut3 (
    .Hclk(clk), .Hresetn(rst), .pwrite(pwrite), .penable(penable), .psel(psel3),
    .paddr(paddr), .pw_data(pw_data), .pr_data(prd3), .pready(pready3), .pslverr(pslverr3));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the completion edge with the bus idle,
  // so consecutive calls produce back-to-back transfers.
  task automatic xfer(input int which, input logic wr, input logic [2:0] sel,
                      input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [31:0] exp_rd, input logic exp_err, input string tag);
    int   waits;
    logic rdy;
    pwrite  = wr;
    paddr   = addr;
    pw_data = wdata;
    penable = 1'b0;
    if (which == 3) begin psel3 = sel; psel0 = '0; end
    else begin psel0 = sel; psel3 = '0; end
    @(negedge clk);
    penable = 1'b1;
    waits = 0;
    rdy = (which == 3) ? pready3 : pready0;
    while (!rdy && waits < 20) begin
      @(negedge clk);
      waits++;
      rdy = (which == 3) ? pready3 : pready0;
    end
    chk({tag, " waits"}, 32'(waits), (which == 3) ? 32'd3 : 32'd0);
    chk({tag, " rdata"}, (which == 3) ? prd3 : prd0, exp_rd);
    chk({tag, " slverr"}, {31'd0, (which == 3) ? pslverr3 : pslverr0}, {31'd0, exp_err});
    @(negedge clk);
    psel0 = '0;
    psel3 = '0;
    penable = 1'b0;
    chk({tag, " ready_drop"}, {31'd0, (which == 3) ? pready3 : pready0}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Reset asserted in the access phase of a write: write must be dropped.
    pwrite = 1'b1; paddr = 32'h0; pw_data = 32'h11111111; psel0 = 3'b001; penable = 1'b0;
    @(negedge clk);
    penable = 1'b1;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst pready0", {31'd0, pready0}, 32'd0);
    chk("rst prdata0", prd0, 32'd0);
    chk("rst pslverr0", {31'd0, pslverr0}, 32'd0);
    chk("rst pready3", {31'd0, pready3}, 32'd0);
    psel0 = '0; penable = 1'b0; rst = 1'b0;
    @(negedge clk);

    for (int b = 0; b < 3; b++)
      for (int w = 0; w < 16; w++)
        xfer(0, 1'b0, 3'(1 << b), 32'(w * 4), 32'd0, 32'd0, 1'b0, "rst_clear");

    // Zero wait states: write then read bank 1 word 2.
    xfer(0, 1'b1, 3'b010, 32'h8, 32'hDEADBEEF, 32'd0, 1'b0, "ws0_wr");
    xfer(0, 1'b0, 3'b010, 32'h8, 32'd0, 32'hDEADBEEF, 1'b0, "ws0_rd");
    xfer(0, 1'b0, 3'b001, 32'h8, 32'd0, 32'd0, 1'b0, "ws0_bank0");
    xfer(0, 1'b0, 3'b100, 32'h8, 32'd0, 32'd0, 1'b0, "ws0_bank2");

    // Error / aliasing cases.
    xfer(0, 1'b1, 3'b001, 32'h40, 32'hCAFEF00D, 32'd0, SLV, "oor_wr");
    xfer(0, 1'b0, 3'b001, 32'h0, 32'd0, SLV ? 32'd0 : 32'hCAFEF00D, 1'b0, "oor_rd0");
    xfer(0, 1'b1, 3'b001, 32'hC, 32'h12345678, 32'd0, 1'b0, "w3");
    xfer(0, 1'b0, 3'b101, 32'hC, 32'd0, SLV ? 32'd0 : 32'h12345678, SLV, "multihot");
    xfer(0, 1'b0, 3'b001, 32'hE, 32'd0, SLV ? 32'd0 : 32'h12345678, SLV, "misalign");

    // Back-to-back write/read pairs across banks, no idle cycles.
    for (int i = 0; i < 8; i++) begin
      xfer(0, 1'b1, 3'(1 << (i % 3)), 32'((i + 4) * 4), 32'hA0000000 | 32'(i * 32'h01010101),
           32'd0, 1'b0, "b2b_wr");
      xfer(0, 1'b0, 3'(1 << (i % 3)), 32'((i + 4) * 4), 32'd0,
           32'hA0000000 | 32'(i * 32'h01010101), 1'b0, "b2b_rd");
    end

    // Three wait states.
    xfer(3, 1'b1, 3'b100, 32'h14, 32'hAAAA5555, 32'd0, 1'b0, "ws3_wr");
    xfer(3, 1'b0, 3'b100, 32'h14, 32'd0, 32'hAAAA5555, 1'b0, "ws3_rd");
    xfer(3, 1'b0, 3'b001, 32'h14, 32'd0, 32'd0, 1'b0, "ws3_bank0");

    // Abort a write during wait states.
    pwrite = 1'b1; paddr = 32'h14; pw_data = 32'h0BAD0BAD; psel3 = 3'b100; penable = 1'b0;
    @(negedge clk);
    penable = 1'b1;
    @(negedge clk);
    chk("abort pready_wait", {31'd0, pready3}, 32'd0);
    psel3 = '0; penable = 1'b0;
    @(negedge clk);
    chk("abort pready_idle", {31'd0, pready3}, 32'd0);
    chk("abort prdata_idle", prd3, 32'd0);
    xfer(3, 1'b0, 3'b100, 32'h14, 32'd0, 32'hAAAA5555, 1'b0, "abort_rd");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
